wcs_loader: RTL and testbench

- Writer-side engine for a 512-word pipelined control store: the RAM counterpart of the registered-output microcode PROM.
- Accepts a stream of microcode words over a valid/ready handshake and writes them to an external writable control store, starting at a base address.
- Optionally reads the region back through the store's pipeline register and compares a modulo checksum.
- Sits between the host/boot interface and the control store; the sequencer reads the store only after done.

---
 rtl/wcs_loader.sv | 175 +++++++++++++++++
 tb/tb_wcs_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wcs_loader.sv
// Loader for a 512-word pipelined writable control store: streams host words into the store
// from a base address, then optionally reads the region back and compares checksums.
module wcs_loader #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned AWIDTH = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] base,
  input  logic [AWIDTH:0]   len,
  input  logic              verify,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [AWIDTH-1:0] ram_a,
  output logic [WIDTH-1:0]  ram_d,
  output logic              ram_we_,
  output logic              ram_oe_,
  input  logic [WIDTH-1:0]  ram_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WIDTH-1:0]  csum
);

  localparam int unsigned CW = AWIDTH + 1;
  localparam logic [CW-1:0] FullLen = {1'b1, {AWIDTH{1'b0}}};

  typedef enum logic [2:0] {StIdle, StLoad, StVerify, StCheck, StDone} state_e;

  state_e state_q, state_d;

  logic [AWIDTH-1:0] ptr_q, ptr_d;
  logic [AWIDTH-1:0] base_q, base_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     len_q, len_d;
  logic              verify_q, verify_d;
  logic [AWIDTH-1:0] ram_a_q, ram_a_d;
  logic [WIDTH-1:0]  ram_d_q, ram_d_d;
  logic              we_q, we_d;
  logic [WIDTH-1:0]  csum_q, csum_d;
  logic [WIDTH-1:0]  rsum_q, rsum_d;
  logic              smp_q, smp_d;
  logic              err_q, err_d;

  logic              accept;
  logic [WIDTH-1:0]  rsum_nxt;

  // cnt_q == 0 in LOAD marks the write-out cycle of the final word.
  assign accept   = (state_q == StLoad) && (cnt_q != '0) && din_valid;
  // ram_q carries the word addressed in the previous cycle whenever smp_q is set.
  assign rsum_nxt = rsum_q + (smp_q ? ram_q : '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StLoad;
      StLoad:   if (cnt_q == '0) state_d = verify_q ? StVerify : StDone;
      StVerify: if (cnt_q == CW'(1)) state_d = StCheck;
      StCheck:  state_d = (rsum_nxt == csum_q) ? StDone : StIdle;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    ptr_d    = ptr_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    verify_d = verify_q;
    ram_a_d  = ram_a_q;
    ram_d_d  = ram_d_q;
    we_d     = 1'b1;
    csum_d   = csum_q;
    rsum_d   = rsum_q;
    err_d    = err_q;
    smp_d    = (state_q == StVerify);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d   = base;
          len_d    = (len == '0) ? FullLen : len;
          cnt_d    = (len == '0) ? FullLen : len;
          verify_d = verify;
          ptr_d    = base;
          err_d    = 1'b0;
          csum_d   = '0;
          rsum_d   = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          ram_a_d = ptr_q;
          ram_d_d = din;
          we_d    = 1'b0;
          ptr_d   = ptr_q + AWIDTH'(1);
          cnt_d   = cnt_q - CW'(1);
          csum_d  = csum_q + din;
        end
        if (cnt_q == '0) begin
          ptr_d = base_q;
          cnt_d = len_q;
        end
      end
      StVerify: begin
        rsum_d = rsum_nxt;
        ptr_d  = ptr_q + AWIDTH'(1);
        cnt_d  = cnt_q - CW'(1);
      end
      StCheck: begin
        rsum_d = rsum_nxt;
        err_d  = (rsum_nxt != csum_q);
      end
      StDone: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      verify_q <= 1'b0;
      ram_a_q  <= '0;
      ram_d_q  <= '0;
      we_q     <= 1'b1;
      csum_q   <= '0;
      rsum_q   <= '0;
      smp_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      verify_q <= verify_d;
      ram_a_q  <= ram_a_d;
      ram_d_q  <= ram_d_d;
      we_q     <= we_d;
      csum_q   <= csum_d;
      rsum_q   <= rsum_d;
      smp_q    <= smp_d;
      err_q    <= err_d;
    end
  end

  // Outputs
  always_comb begin
    din_ready = (state_q == StLoad) && (cnt_q != '0) && !rst;
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    ram_oe_   = (state_q != StVerify);
    ram_a     = (state_q == StVerify) ? ptr_q : ram_a_q;
    ram_d     = ram_d_q;
    ram_we_   = we_q;
    err       = err_q;
    csum      = csum_q;
  end

endmodule

// File: tb/tb_wcs_loader.sv
// Bench for wcs_loader: a model control store plus table-driven, hand-written and random loads.
module tb_wcs_loader;

  localparam int DEPTH = 512;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] base;
  logic [9:0] len;
  logic       verify;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [8:0] ram_a;
  logic [7:0] ram_d;
  logic       ram_we_;
  logic       ram_oe_;
  logic [7:0] ram_q;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] csum;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wcs_loader #(.WIDTH(8), .AWIDTH(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .len       (len),
    .verify    (verify),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .ram_a     (ram_a),
    .ram_d     (ram_d),
    .ram_we_   (ram_we_),
    .ram_oe_   (ram_oe_),
    .ram_q     (ram_q),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .csum      (csum)
  );

  // Model control store with registered output and an optional stuck-at-zero cell.
  logic [7:0] mem [DEPTH];
  logic       corrupt_en;
  logic [8:0] corrupt_a;

  always @(posedge clk) begin
    if (!ram_we_) mem[ram_a] <= (corrupt_en && ram_a == corrupt_a) ? 8'h00 : ram_d;
    if (!ram_oe_) ram_q <= mem[ram_a];
  end

  // Logs of every write strobe and done pulse seen on the store side.
  logic [8:0]  wa_q [$];
  logic [7:0]  wd_q [$];
  int unsigned done_cycs [$];

  always @(negedge clk) begin
    if (!ram_we_) begin
      wa_q.push_back(ram_a);
      wd_q.push_back(ram_d);
    end
    if (done) done_cycs.push_back(cyc);
  end

  logic [7:0] dat [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // mode: 0 valid held high, 1 valid on alternate cycles, 2 random valid.
  task automatic run_load(input string tag, input logic [8:0] b, input logic [9:0] l,
                          input bit v, input int mode, input bit poke_start,
                          input logic [7:0] exp_csum, input bit exp_err, input bit exp_done);
    int n, wb, db, i, k, nw, s, lat;
    bit acc;
    n  = (l == 10'd0) ? DEPTH : int'(l);
    wb = wa_q.size();
    db = done_cycs.size();
    @(posedge clk); #1;
    start = 1'b1; base = b; len = l; verify = v; din_valid = 1'b0;
    s = int'(cyc);
    @(posedge clk); #1;
    start = 1'b0;
    i = 0;
    k = 0;
    while (i < n && k < 4 * n + 40) begin
      case (mode)
        1:       din_valid = (k % 2) == 1;
        2:       din_valid = 1'($urandom_range(0, 1));
        default: din_valid = 1'b1;
      endcase
      din = dat[i];
      if (poke_start) begin
        start = 1'($urandom_range(0, 1));
        base  = 9'($urandom);
      end
      @(negedge clk);
      acc = din_valid && din_ready;
      @(posedge clk); #1;
      if (acc) i++;
      k++;
    end
    start = 1'b0;
    din_valid = 1'b0;
    chk($sformatf("%s accepted", tag), 32'(i), 32'(n));
    @(negedge clk);
    chk($sformatf("%s ready_drop", tag), 32'(din_ready), 32'd0);
    for (int t = 0; t < 3 * n + 40; t++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk($sformatf("%s idle", tag), 32'(busy), 32'd0);
    nw = wa_q.size() - wb;
    chk($sformatf("%s wr_count", tag), 32'(nw), 32'(n));
    for (int j = 0; j < n && j < nw; j++) begin
      chk($sformatf("%s wr_addr[%0d]", tag, j), 32'(wa_q[wb + j]), 32'((int'(b) + j) % DEPTH));
      chk($sformatf("%s wr_data[%0d]", tag, j), 32'(wd_q[wb + j]), 32'(dat[j]));
    end
    chk($sformatf("%s csum", tag), 32'(csum), 32'(exp_csum));
    chk($sformatf("%s err", tag), 32'(err), 32'(exp_err));
    chk($sformatf("%s done_count", tag), 32'(done_cycs.size() - db), 32'(exp_done));
    if (exp_done && mode == 0 && done_cycs.size() > db) begin
      lat = v ? 2 * n + 3 : n + 2;
      chk($sformatf("%s done_latency", tag), 32'(int'(done_cycs[db]) - s), 32'(lat));
    end
  endtask

  typedef struct {
    logic [8:0] base;
    logic [9:0] len;
    bit         verify;
    int         mode;
    bit         corrupt;
    logic [8:0] caddr;
    logic [7:0] exp_csum;
    bit         exp_err;
    bit         exp_done;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int wb, n, ck, sum;
    bit ex_err;
    logic [8:0] rb;

    // FC+FB+FA+F9 = 0x3EA; 512 words of (FC-i) cover every byte value twice -> 0x00.
    tbl[0] = '{9'h003, 10'd4, 1'b0, 0, 1'b0, 9'h000, 8'hEA, 1'b0, 1'b1};
    tbl[1] = '{9'h003, 10'd4, 1'b0, 1, 1'b0, 9'h000, 8'hEA, 1'b0, 1'b1};
    tbl[2] = '{9'h1FE, 10'd4, 1'b0, 0, 1'b0, 9'h000, 8'hEA, 1'b0, 1'b1};
    tbl[3] = '{9'h003, 10'd4, 1'b1, 0, 1'b0, 9'h000, 8'hEA, 1'b0, 1'b1};
    tbl[4] = '{9'h003, 10'd4, 1'b1, 0, 1'b1, 9'h005, 8'hEA, 1'b1, 1'b0};
    tbl[5] = '{9'h1FF, 10'd1, 1'b1, 0, 1'b0, 9'h000, 8'hFC, 1'b0, 1'b1};
    tbl[6] = '{9'h100, 10'd0, 1'b1, 0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b1};
    tbl[7] = '{9'h1FE, 10'd4, 1'b1, 1, 1'b0, 9'h000, 8'hEA, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; base = '0; len = '0; verify = 1'b0;
    din = '0; din_valid = 1'b0; corrupt_en = 1'b0; corrupt_a = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ram_a", 32'(ram_a), 32'd0);
    chk("rst ram_d", 32'(ram_d), 32'd0);
    chk("rst ram_we_", 32'(ram_we_), 32'd1);
    chk("rst ram_oe_", 32'(ram_oe_), 32'd1);
    chk("rst din_ready", 32'(din_ready), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst csum", 32'(csum), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      for (int j = 0; j < DEPTH; j++) dat[j] = 8'(252 - j);
      corrupt_en = tbl[v].corrupt;
      corrupt_a  = tbl[v].caddr;
      run_load($sformatf("vec%0d", v), tbl[v].base, tbl[v].len, tbl[v].verify, tbl[v].mode,
               1'b0, tbl[v].exp_csum, tbl[v].exp_err, tbl[v].exp_done);
    end
    corrupt_en = 1'b0;

    // Reset after two of four accepted words: the pending write completes, nothing after it.
    wb = wa_q.size();
    @(posedge clk); #1;
    start = 1'b1; base = 9'h003; len = 10'd4; verify = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; din_valid = 1'b1; din = 8'hFC;
    @(posedge clk); #1;
    din = 8'hFB;
    @(posedge clk); #1;
    din_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst csum", 32'(csum), 32'd0);
    chk("midrst ram_we_", 32'(ram_we_), 32'd1);
    chk("midrst din_ready", 32'(din_ready), 32'd0);
    repeat (6) @(negedge clk);
    chk("midrst wr_count", 32'(wa_q.size() - wb), 32'd2);

    // Random loads, expectations from plain arithmetic over the word list.
    for (int r = 0; r < 8; r++) begin
      n  = int'($urandom_range(1, 24));
      rb = 9'($urandom);
      sum = 0;
      for (int j = 0; j < n; j++) begin
        dat[j] = 8'($urandom);
        sum += int'(dat[j]);
      end
      ck = int'($urandom_range(0, n - 1));
      corrupt_en = 1'($urandom_range(0, 1));
      corrupt_a  = 9'((int'(rb) + ck) % DEPTH);
      verify     = 1'($urandom_range(0, 1));
      ex_err     = verify && corrupt_en && (dat[ck] != 8'h00);
      run_load($sformatf("rnd%0d", r), rb, 10'(n), verify, int'($urandom_range(0, 2)), 1'b1,
               8'(sum % 256), ex_err, !ex_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
